r_multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the R-type CPU datapath (instruction fetch unit, register file, ALU, ZF/OF flag register). It replaces single-cycle combinational decode with a five-state FSM. The FSM handshakes with instruction memory, strobes the instruction register and PC, latches operands and the ALU result, updates the flags, and writes back. It also traps unsupported encodings and counts retired instructions.

---
 rtl/r_multicycle_ctrl.sv | 137 +++++++++++++
 tb/tb_r_multicycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/r_multicycle_ctrl.sv
// Five-state multi-cycle sequencer for the R-type datapath: fetch handshake,
// decode/trap, ALU/flag strobes, write-back and a retired-instruction counter.
module r_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             imem_ack,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             ab_write,
    output logic             alu_out_write,
    output logic [2:0]       alu_op,
    output logic             set_zf,
    output logic             set_of,
    output logic             write_reg,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] inst_count
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_WB   = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       alu_op_q, dec_alu_op;
    logic             of_en_q, dec_of_en, dec_valid;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;

    // R-type decode; only meaningful while IR is valid (ID cycle).
    always_comb begin
        dec_valid  = 1'b0;
        dec_alu_op = 3'b000;
        dec_of_en  = 1'b0;
        if (op == 6'b000000) begin
            dec_valid = 1'b1;
            case (func)
                6'b100000: begin dec_alu_op = 3'b100; dec_of_en = 1'b1; end
                6'b100010: begin dec_alu_op = 3'b101; dec_of_en = 1'b1; end
                6'b100100: dec_alu_op = 3'b000;
                6'b100101: dec_alu_op = 3'b001;
                6'b100110: dec_alu_op = 3'b010;
                6'b100111: dec_alu_op = 3'b011;
                6'b101011: dec_alu_op = 3'b110;
                6'b000100: dec_alu_op = 3'b111;
                default:   dec_valid  = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        ab_write      = 1'b0;
        alu_out_write = 1'b0;
        set_zf        = 1'b0;
        set_of        = 1'b0;
        write_reg     = 1'b0;
        case (state_q)
            S_IF: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                ab_write = 1'b1;
                state_d  = dec_valid ? S_EX : S_HALT;
            end
            S_EX: begin
                alu_out_write = 1'b1;
                set_zf        = 1'b1;
                set_of        = of_en_q;
                state_d       = S_WB;
            end
            S_WB: begin
                write_reg = 1'b1;
                state_d   = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
        // Reset silences every strobe in the cycle it is asserted.
        if (rst) begin
            state_d       = S_IF;
            imem_req      = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            ab_write      = 1'b0;
            alu_out_write = 1'b0;
            set_zf        = 1'b0;
            set_of        = 1'b0;
            write_reg     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IF;
            alu_op_q  <= 3'b000;
            of_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) begin
                if (dec_valid) begin
                    alu_op_q <= dec_alu_op;
                    of_en_q  <= dec_of_en;
                end else begin
                    illegal_q <= 1'b1;
                end
            end
            if (state_q == S_WB)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign alu_op     = alu_op_q;
    assign illegal    = illegal_q;
    assign state      = state_q;
    assign inst_count = cnt_q;

endmodule

// File: tb/tb_r_multicycle_ctrl.sv
// Randomized bench for r_multicycle_ctrl: per-instruction expected cycle
// traces are built from the instruction-level behaviour and compared each cycle.
module tb_r_multicycle_ctrl;
    localparam int CW = 8;
    localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2, ST_WB = 3'd3, ST_HALT = 3'd4;

    logic clk = 1'b0;
    logic rst, imem_ack;
    logic [5:0] op, func;
    logic imem_req, ir_write, pc_write, ab_write, alu_out_write, set_zf, set_of, write_reg, illegal;
    logic [2:0] alu_op, state;
    logic [CW-1:0] inst_count;

    r_multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .imem_ack(imem_ack),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .ab_write(ab_write), .alu_out_write(alu_out_write), .alu_op(alu_op),
        .set_zf(set_zf), .set_of(set_of), .write_reg(write_reg),
        .illegal(illegal), .state(state), .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic req, irw, pcw, abw, aow, szf, sof, wr, ill;
        logic [2:0] aop;
        logic [CW-1:0] cnt;
    } obs_t;

    int n_chk = 0, n_pass = 0;
    int unsigned m_cnt = 0;
    logic [2:0] m_aop = 3'b000;
    bit m_aop_ok = 1'b1;

    localparam logic [5:0] FUNCS [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                         6'b100110, 6'b100111, 6'b101011, 6'b000100};

    function automatic bit ref_decode(input logic [5:0] o, input logic [5:0] f,
                                      output logic [2:0] aop, output logic ofen);
        aop = 3'b000; ofen = 1'b0;
        if (o != 6'd0) return 1'b0;
        case (f)
            6'b100000: begin aop = 3'b100; ofen = 1'b1; end
            6'b100010: begin aop = 3'b101; ofen = 1'b1; end
            6'b100100: aop = 3'b000;
            6'b100101: aop = 3'b001;
            6'b100110: aop = 3'b010;
            6'b100111: aop = 3'b011;
            6'b101011: aop = 3'b110;
            6'b000100: aop = 3'b111;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic obs_t base(input logic [2:0] st);
        obs_t e;
        e = '0;
        e.st = st;
        e.aop = m_aop;
        e.cnt = m_cnt[CW-1:0];
        return e;
    endfunction

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    // One clock: drive inputs, sample outputs at the falling edge, pass the rising edge.
    task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic ack, output obs_t g);
        rst = r; op = o; func = f; imem_ack = ack;
        @(negedge clk);
        g.st = state; g.req = imem_req; g.irw = ir_write; g.pcw = pc_write;
        g.abw = ab_write; g.aow = alu_out_write; g.szf = set_zf; g.sof = set_of;
        g.wr = write_reg; g.ill = illegal; g.aop = alu_op; g.cnt = inst_count;
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string name);
        obs_t e, g;
        cyc(1'b1, rnd6(), rnd6(), 1'b1, g);
        n_chk++;
        if ({g.req, g.irw, g.pcw, g.abw, g.aow, g.szf, g.sof, g.wr} !== 8'b0)
            $display("FAIL %s rst-cycle strobes: got %b expected 00000000", name,
                     {g.req, g.irw, g.pcw, g.abw, g.aow, g.szf, g.sof, g.wr});
        else n_pass++;
        m_cnt = 0; m_aop = 3'b000; m_aop_ok = 1'b1;
        e = base(ST_IF);
        cyc(1'b1, rnd6(), rnd6(), 1'b1, g);
        n_chk++;
        if (g !== e) $display("FAIL %s held-reset: got %h expected %h", name, g, e);
        else n_pass++;
    endtask

    task automatic exec_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                              input int delay, input int halt_cycles, output bit legal);
        obs_t e, g;
        logic [2:0] a;
        logic oe;
        legal = ref_decode(o, f, a, oe);
        for (int k = 0; k < delay; k++) begin
            e = base(ST_IF); e.req = 1'b1;
            cyc(1'b0, rnd6(), rnd6(), 1'b0, g);
            n_chk++;
            if (g !== e) $display("FAIL %s IF-wait%0d: got %h expected %h", name, k, g, e);
            else n_pass++;
        end
        e = base(ST_IF); e.req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        cyc(1'b0, rnd6(), rnd6(), 1'b1, g);
        n_chk++;
        if (g !== e) $display("FAIL %s IF-ack: got %h expected %h", name, g, e);
        else n_pass++;
        e = base(ST_ID); e.abw = 1'b1;
        cyc(1'b0, o, f, 1'($urandom), g);
        n_chk++;
        if (g !== e) $display("FAIL %s ID: got %h expected %h", name, g, e);
        else n_pass++;
        if (legal) begin
            m_aop = a;
            e = base(ST_EX); e.aow = 1'b1; e.szf = 1'b1; e.sof = oe;
            cyc(1'b0, rnd6(), rnd6(), 1'($urandom), g);
            n_chk++;
            if (g !== e) $display("FAIL %s EX: got %h expected %h", name, g, e);
            else n_pass++;
            e = base(ST_WB); e.wr = 1'b1;
            cyc(1'b0, rnd6(), rnd6(), 1'($urandom), g);
            n_chk++;
            if (g !== e) $display("FAIL %s WB: got %h expected %h", name, g, e);
            else n_pass++;
            m_cnt++;
        end else begin
            // alu_op after a trapped decode is not constrained; mask it until reset.
            m_aop_ok = 1'b0;
            for (int k = 0; k < halt_cycles; k++) begin
                e = base(ST_HALT); e.ill = 1'b1;
                cyc(1'b0, rnd6(), rnd6(), 1'($urandom), g);
                if (!m_aop_ok) g.aop = e.aop;
                n_chk++;
                if (g !== e) $display("FAIL %s HALT%0d: got %h expected %h", name, k, g, e);
                else n_pass++;
            end
        end
    endtask

    // Run a legal instruction and assert rst during the given stage (0=IF..3=WB).
    task automatic abort_at(input string name, input logic [5:0] f, input int stage);
        obs_t e, g;
        logic [2:0] a;
        logic oe;
        logic [2:0] sts [4];
        void'(ref_decode(6'd0, f, a, oe));
        sts = '{ST_IF, ST_ID, ST_EX, ST_WB};
        for (int s = 0; s <= stage; s++) begin
            e = base(sts[s]);
            if (s == stage) begin
                cyc(1'b1, (s == 1) ? 6'd0 : rnd6(), (s == 1) ? f : rnd6(), 1'b1, g);
            end else begin
                case (s)
                    0: begin e.req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; end
                    1: e.abw = 1'b1;
                    default: begin e.aow = 1'b1; e.szf = 1'b1; e.sof = oe; end
                endcase
                cyc(1'b0, (s == 1) ? 6'd0 : rnd6(), (s == 1) ? f : rnd6(), (s == 0), g);
                if (s == 1) m_aop = a;
            end
            n_chk++;
            if (g !== e) $display("FAIL %s stage%0d: got %h expected %h", name, s, g, e);
            else n_pass++;
        end
        m_cnt = 0; m_aop = 3'b000; m_aop_ok = 1'b1;
        e = base(ST_IF); e.req = 1'b1;
        cyc(1'b0, rnd6(), rnd6(), 1'b0, g);
        n_chk++;
        if (g !== e) $display("FAIL %s after-rst: got %h expected %h", name, g, e);
        else n_pass++;
    endtask

    task automatic test_reset();
        obs_t e, g;
        do_reset("reset");
        e = base(ST_IF); e.req = 1'b1;
        cyc(1'b0, rnd6(), rnd6(), 1'b0, g);
        n_chk++;
        if (g !== e) $display("FAIL reset first-cycle: got %h expected %h", g, e);
        else n_pass++;
    endtask

    task automatic test_add();
        bit l;
        exec_instr("add", 6'd0, 6'b100000, 0, 0, l);
    endtask

    task automatic test_and_delay();
        bit l;
        exec_instr("and_delay", 6'd0, 6'b100100, 3, 0, l);
    endtask

    task automatic test_illegal();
        bit l;
        exec_instr("illegal", 6'b100011, rnd6(), 0, 12, l);
        do_reset("illegal_reset");
    endtask

    task automatic test_back_to_back();
        bit l;
        exec_instr("b2b_sll", 6'd0, 6'b000100, 0, 0, l);
        exec_instr("b2b_slt", 6'd0, 6'b101011, 0, 0, l);
        n_chk++;
        if (inst_count !== 8'd2) $display("FAIL b2b count: got %0d expected 2", inst_count);
        else n_pass++;
    endtask

    task automatic test_rst_mid();
        bit l;
        abort_at("rst_ex_sub", 6'b100010, 2);
        exec_instr("pre_wb", 6'd0, 6'b100101, 1, 0, l);
        abort_at("rst_wb", 6'b100110, 3);
        abort_at("rst_if", 6'b100000, 0);
        abort_at("rst_id", 6'b100111, 1);
    endtask

    task automatic test_wrap();
        bit l;
        do_reset("wrap_reset");
        for (int i = 0; i < 260; i++)
            exec_instr("wrap", 6'd0, FUNCS[$urandom_range(7)], 0, 0, l);
    endtask

    task automatic test_random();
        bit l;
        logic [5:0] o, f;
        for (int i = 0; i < 150; i++) begin
            o = ($urandom_range(7) == 0) ? rnd6() : 6'd0;
            f = ($urandom_range(3) == 0) ? rnd6() : FUNCS[$urandom_range(7)];
            if ($urandom_range(19) == 0) begin
                abort_at("rand_abort", FUNCS[$urandom_range(7)], $urandom_range(3));
            end else begin
                exec_instr("random", o, f, $urandom_range(3), 3, l);
                if (!l) do_reset("random_reset");
            end
        end
    endtask

    initial begin
        rst = 1'b1; op = 6'd0; func = 6'd0; imem_ack = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_and_delay();
        test_illegal();
        test_back_to_back();
        test_rst_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
